// File: rtl/btn_pulse_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_pulse_debouncer                                          |
// | Description : Push-button conditioner. Raw asynchronous button in, clean   |
// |               debounced level plus single-cycle press/release strobes out. |
// |               2-flop synchronizer, stability counter and 4-state FSM.      |
// |               Optional auto-repeat of btn_pulse while held is enabled by   |
// |               defining the macro AUTO_REPEAT_EN.                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module btn_pulse_debouncer #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned RPT_W         = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);

  // Last count value of a stability check: reaching it with the input still
  // stable accepts the new level.
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_PRESSED   = 2'd2,
    S_REL_CHK   = 2'd3
  } state_e;

  // Reject parameter sets the counters cannot represent.
  if (STABLE_CYCLES < 2 || (STABLE_CYCLES >> CNT_W) != 0) begin : g_bad_stable
    $error("btn_pulse_debouncer: STABLE_CYCLES must be >= 2 and < 2**CNT_W");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      (REPEAT_DELAY >> RPT_W) != 0 || (REPEAT_PERIOD >> RPT_W) != 0) begin : g_bad_repeat
    $error("btn_pulse_debouncer: REPEAT_DELAY/REPEAT_PERIOD must be >= 1 and < 2**RPT_W");
  end

  logic             sync0_q;
  logic             sync1_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [RPT_W-1:0] c_RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] c_RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  // rpt_q counts held cycles; rpt_armed_q is set once the initial delay has
  // elapsed, after which rpt_q measures the shorter repeat period.
  logic [RPT_W-1:0] rpt_q;
  logic             rpt_armed_q;
`endif

  // Two-flop synchronizer bringing the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= btn_in;
      sync1_q <= sync0_q;
    end
  end

  // Debounce FSM with registered level and strobe outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; only the accepting transitions raise them.
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef AUTO_REPEAT_EN
          rpt_q       <= '0;
          rpt_armed_q <= 1'b0;
`endif
          if (sync1_q) begin
            state_q <= S_PRESS_CHK;
            cnt_q   <= '0;
          end
        end

        S_PRESS_CHK: begin
          if (!sync1_q) begin
            state_q <= S_IDLE;
          end else if (cnt_q == c_CNT_LAST) begin
            state_q   <= S_PRESSED;
            btn_level <= 1'b1;
            btn_pulse <= 1'b1;
`ifdef AUTO_REPEAT_EN
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_PRESSED: begin
          if (!sync1_q) begin
            state_q <= S_REL_CHK;
            cnt_q   <= '0;
          end
`ifdef AUTO_REPEAT_EN
          // Repeat timing only advances while the button is seen held.
          else if (!rpt_armed_q && rpt_q == c_RPT_DELAY_LAST) begin
            btn_pulse   <= 1'b1;
            rpt_q       <= '0;
            rpt_armed_q <= 1'b1;
          end else if (rpt_armed_q && rpt_q == c_RPT_PERIOD_LAST) begin
            btn_pulse <= 1'b1;
            rpt_q     <= '0;
          end else begin
            rpt_q <= rpt_q + RPT_W'(1);
          end
`endif
        end

        S_REL_CHK: begin
          // A bounce back high resumes PRESSED without a new press strobe;
          // the repeat counter is left frozen meanwhile.
          if (sync1_q) begin
            state_q <= S_PRESSED;
          end else if (cnt_q == c_CNT_LAST) begin
            state_q     <= S_IDLE;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
